// File: rtl/param_seq_gen.sv
// Ramp/constant multi-channel sample generator feeding an output FIFO.
// Defining PARAM_SEQ_GEN_WRAP_EN enables the sticky accumulator-wrap flag.
module param_seq_gen #(
  parameter int X     = 1,
  parameter int FIVE  = 0,
  parameter int TWO   = 2,
  parameter int NCH   = 2,
  parameter int DEPTH = 4,
  parameter int LEN   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [X:0] out_data,
  output logic [3:0] out_chan,
  output logic [4:0] par,
  output logic       busy,
  output logic       done,
  output logic       wrap
);

  localparam int          AW       = $clog2(DEPTH);
  localparam int          LAST_I   = LEN - 1;
  localparam int          LAST_C   = NCH - 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  localparam logic [15:0] LAST_IDX = LAST_I[15:0];
  localparam logic [3:0]  LAST_CH  = LAST_C[3:0];
  localparam logic [X:0]  TWO_T    = TWO[X:0];
  localparam bit          RAMP     = (FIVE == 5);
  localparam logic [X:0]  STEP     = RAMP ? TWO_T : '0;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [X:0]    r_acc [16];
  logic [3:0]    r_ch;
  logic [15:0]   r_sent;
  logic [X:0]    r_mem_data [DEPTH];
  logic [3:0]    r_mem_chan [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_done;

  logic          w_start;
  logic          w_push;
  logic          w_pop;
  logic          w_last;
  logic [X:0]    w_sample;

  assign w_start  = (r_state == S_IDLE) && start;
  // Fullness uses the pre-pop occupancy so a stalled consumer never lets us overrun.
  assign w_push   = (r_state == S_RUN) && !stop && (r_count != FULL_CNT);
  assign w_pop    = out_valid && out_ready;
  assign w_last   = w_push && (r_sent == LAST_IDX);
  assign w_sample = RAMP ? r_acc[r_ch] : TWO_T;

  // NOTE: state register uses non-blocking assignments; the next state is pure combinational.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= (r_state == S_DRAIN) && (w_next_state == S_IDLE);
    end
  end

  // NOTE: default assigned first so no path leaves w_next_state unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_RUN;
      S_RUN:   if (stop || w_last) w_next_state = S_DRAIN;
      S_DRAIN: if (r_count == '0) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) r_acc[i] <= '0;
      r_ch   <= '0;
      r_sent <= '0;
    end else if (w_start) begin
      for (int i = 0; i < 16; i++) r_acc[i] <= '0;
      r_ch   <= '0;
      r_sent <= '0;
    end else if (w_push) begin
      r_acc[r_ch] <= r_acc[r_ch] + STEP;
      r_ch        <= (r_ch == LAST_CH) ? 4'd0 : r_ch + 4'd1;
      r_sent      <= r_sent + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is not reset; occupancy gates everything visible, so stale words never leak out.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= w_sample;
      r_mem_chan[r_wr_ptr] <= r_ch;
    end
  end

  assign out_valid = (r_count != '0);
  assign out_data  = out_valid ? r_mem_data[r_rd_ptr] : '0;
  assign out_chan  = out_valid ? r_mem_chan[r_rd_ptr] : 4'd0;
  assign par       = X[4:0];
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;

`ifdef PARAM_SEQ_GEN_WRAP_EN
  logic         r_wrap;
  logic [X+1:0] w_sum;

  assign w_sum = {1'b0, r_acc[r_ch]} + {1'b0, STEP};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_wrap <= 1'b0;
    else if (w_start)              r_wrap <= 1'b0;
    else if (w_push && w_sum[X+1]) r_wrap <= 1'b1;
  end

  assign wrap = r_wrap;
`else
  assign wrap = 1'b0;
`endif

endmodule
